// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the single-cycle pipeline result and a 2-entry
// long-latency FIFO onto the register-file write port, with WAW squash and starvation bound.
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid,
  input  logic [AW-1:0]   pipe_adr,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_stall,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [AW-1:0]   lu_adr,
  input  logic [XLEN-1:0] lu_data,
  output logic            en,
  output logic [AW-1:0]   w_adr,
  output logic [XLEN-1:0] w_data,
  output logic [1:0]      pend_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef struct packed {
    logic [AW-1:0]   adr;
    logic [XLEN-1:0] data;
  } slot_t;

  // Which source, if any, owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_HEAD,
    SRC_DROP
  } src_e;

  slot_t [1:0] slot_q, slot_n;
  logic  [1:0] live_q, live_n;
  logic  [1:0] cnt_q, cnt_n;
  logic  [3:0] starve_q, starve_n;
  logic        ready_en_q;

  src_e        src;
  logic        pipe_eff;
  logic        head_live;
  logic        force_head;
  logic        pop;
  logic        push;
  logic        push_live;
  logic        push_idx;
  logic  [1:0] squash;

  assign pipe_eff   = pipe_valid && (pipe_adr != '0);
  assign head_live  = (cnt_q != 2'd0) && live_q[0];
  assign force_head = (starve_q == STARVE_LIM) && head_live;
  assign pipe_stall = pipe_eff && force_head;

  assign lu_ready = (cnt_q != 2'd2) && ready_en_q;
  assign pend_cnt = cnt_q;

  // NOTE: every signal driven in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    src      = SRC_NONE;
    starve_n = '0;
    if (force_head) begin
      src = SRC_HEAD;
    end else if (pipe_eff) begin
      src = SRC_PIPE;
      if (cnt_q != 2'd0)
        starve_n = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
    end else if (cnt_q != 2'd0) begin
      src = live_q[0] ? SRC_HEAD : SRC_DROP;
    end
  end

  assign pop  = (src == SRC_HEAD) || (src == SRC_DROP);
  assign push = lu_valid && lu_ready && (lu_adr != '0);

  // A younger pipe write to the same register kills older buffered results, including one arriving now.
  assign squash[0] = (src == SRC_PIPE) && (slot_q[0].adr == pipe_adr);
  assign squash[1] = (src == SRC_PIPE) && (slot_q[1].adr == pipe_adr);
  assign push_live = !((src == SRC_PIPE) && (lu_adr == pipe_adr));
  assign push_idx  = (cnt_q == 2'd1) && !pop;

  always_comb begin
    slot_n = slot_q;
    live_n = live_q & ~squash;
    if (pop) begin
      slot_n[0] = slot_q[1];
      live_n[0] = live_q[1] & ~squash[1];
      live_n[1] = 1'b0;
    end
    if (push) begin
      slot_n[push_idx].adr  = lu_adr;
      slot_n[push_idx].data = lu_data;
      live_n[push_idx]      = push_live;
    end
    cnt_n = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      live_q     <= '0;
      starve_q   <= '0;
      ready_en_q <= 1'b0;
      en         <= 1'b0;
      w_adr      <= '0;
      w_data     <= '0;
    end else begin
      cnt_q      <= cnt_n;
      live_q     <= live_n;
      starve_q   <= starve_n;
      ready_en_q <= 1'b1;
      en         <= 1'b0;
      case (src)
        SRC_PIPE: begin
          en     <= 1'b1;
          w_adr  <= pipe_adr;
          w_data <= pipe_data;
        end
        SRC_HEAD: begin
          en     <= 1'b1;
          w_adr  <= slot_q[0].adr;
          w_data <= slot_q[0].data;
        end
        default: ;
      endcase
    end
  end

  // NOTE: slot payloads are not reset; cnt_q and live_q alone decide whether a slot means anything.
  always_ff @(posedge clk) begin
    slot_q <= slot_n;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter in front of the OTTER register file write port. It merges results from two sources into the single `w_data`/`w_adr`/`en` write port. One source is the single-cycle pipeline result, which has priority. The other is a long-latency unit (multiply/divide/load) that feeds a 2-entry FIFO over a valid/ready handshake. The arbiter squashes buffered long-latency results that a younger pipeline write overtakes (WAW ordering), and it bounds starvation of the long-latency unit.

## Interface
- `XLEN`, 32, data width
- `AW`, 5, register address width
- `STARVE_MAX`, 4, consecutive pipeline wins tolerated before the FIFO head is forced out (range 1..15)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `pipe_valid`  in  1  pipeline result present
- `pipe_adr`  in  AW  pipeline destination register
- `pipe_data`  in  XLEN  pipeline result
- `pipe_stall`  out  1  pipeline result not taken this cycle; upstream holds `pipe_*`
- `lu_valid`  in  1  long-latency result offered
- `lu_ready`  out  1  FIFO can accept
- `lu_adr`  in  AW  long-latency destination register
- `lu_data`  in  XLEN  long-latency result
- `en`  out  1  register-file write enable (registered)
- `w_adr`  out  AW  register-file write address (registered)
- `w_data`  out  XLEN  register-file write data (registered)
- `pend_cnt`  out  2  FIFO occupancy, valid and squashed entries (0..2)

## Operation
- Pipe request is effective when `pipe_valid && pipe_adr != 0`. A pipe write to x0 is ignored: it never stalls and never issues.
- FIFO: 2 entries, each holding {adr, data, live}. Push when `lu_valid && lu_ready`. If `lu_adr == 0`, the handshake completes but nothing is stored.
- `lu_ready = (pend_cnt != 2) && ready_en`. `ready_en` is a flop that reset clears and that sets on the first clock edge after `rst_n` rises. There is no pass-through when full, even if a pop occurs that cycle.
- Per-cycle issue decision, in priority order:
  1. `force` = `starve_cnt == STARVE_MAX` and FIFO head live. The head issues, `pipe_stall = 1`, the head pops, and `starve_cnt` clears to 0.
  2. Pipe effective: the pipe issues and `pipe_stall = 0`. `starve_cnt` increments (saturating at STARVE_MAX) if the FIFO is non-empty, else it clears.
  3. FIFO non-empty: the head pops. If the head is live, it issues. If squashed, `en` is 0 next cycle. `starve_cnt` clears.
  4. Otherwise: nothing issues and `starve_cnt` clears.
- `pipe_stall` is 0 whenever the pipe is not effective.
- Issue sets the output flops on the next edge: `en <= 1`, plus `w_adr` and `w_data` from the issuing source. With no issue, `en <= 0` and `w_adr`/`w_data` hold their values.
- Squash: when the pipe issues to address A, every FIFO entry with adr == A clears its live bit. A same-cycle push with `lu_adr == A` is stored with live = 0, because the long-latency result is older.
- Push, pop and squash in one cycle all apply. The occupancy change is +1, 0 or -1.
- Pushes preserve FIFO order. Squashed entries keep their slot until popped.

## Timing
- Input to `en`/`w_adr`/`w_data` latency: 1 cycle. The register file commits on the following edge, 2 edges after the input is presented.
- `pipe_stall`: combinational from `pipe_valid`, `pipe_adr`, `starve_cnt` and the head live bit. It has no path from `lu_*`.
- `lu_ready` and `pend_cnt`: from flops only.
- Reset values, applied asynchronously on `rst_n` low:
  - `en` = 0, `w_adr` = 0, `w_data` = 0
  - FIFO empty, `pend_cnt` = 0, `starve_cnt` = 0
  - `ready_en` = 0, hence `lu_ready` = 0 and `pipe_stall` = 0
- Reset mid-operation discards FIFO contents. No write is issued after reset asserts.
- Throughput: one register-file write per cycle maximum. A squashed head costs one idle cycle.

## Test plan
- Reset, then `pipe_valid=1, pipe_adr=5, pipe_data=0xDEADBEEF` for one cycle -> on the next cycle `en=1, w_adr=5, w_data=0xDEADBEEF`; on the cycle after, `en=0`. `lu_ready=0` while reset is asserted and goes to 1 one edge after release.
- Push lu {x7, 0x11}, then {x8, 0x22}, with no pipe traffic -> `pend_cnt` 1 then 2 and `lu_ready=0` when full. The writes come out in order: x7/0x11, then x8/0x22.
- FIFO holds {x9, 0xAA}; the pipe writes x9 = 0xBB -> a single `en` pulse for x9/0xBB. The FIFO pop costs one idle cycle with `en=0`, and 0xAA is never written.
- FIFO non-empty with the pipe writing x3 every cycle and `STARVE_MAX=4` -> 4 pipe writes, then one cycle with `pipe_stall=1` and the head issued, then the held pipe write to x3 issues.
- `pipe_adr=0` and `lu_adr=0` traffic -> `en` never asserts, `pend_cnt` stays 0, and the lu handshake still completes.
- Assert `rst_n=0` asynchronously mid-burst with 2 entries pending -> `en`, `pend_cnt` and `lu_ready` drop to 0 immediately, without waiting for a clock edge, and no pending entry is written after release.
